// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared encodings for the RV32I/M decode-control pipeline: opcodes, operand selects,
// immediate formats, M-op FSM states and the E-stage control record.
package decode_ctrl_pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_ALUREG = 7'h33;
    localparam logic [6:0] OP_ALUIMM = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_U     = 3'd1;
    localparam logic [2:0] IMM_LS    = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_J     = 3'd4;
    localparam logic [2:0] IMM_OTHER = 3'd5;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_ZERO = 2'b01;
    localparam logic [1:0] SRCA_RS1  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    // START is the first E cycle of an M op; BUSY covers the remaining occupancy.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_e;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       reg_write;
        logic       mem_write;
        logic       pc_branch;
        logic       mem_to_reg;
        logic [4:0] alu_op;
        logic [2:0] imm_sel;
        logic [2:0] str_ctrl;
        logic [1:0] src_a;
        logic [1:0] src_b;
    } ctrl_t;

endpackage

// File: rtl/decode_ctrl_pipe_ctrl_decode.sv
// Combinational RV32I/M control decode including illegal-encoding detection.
// An invalid D slot decodes to an all-zero bubble.
module ctrl_decode
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int EN_M = 1
)
(
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output ctrl_t      ctrl_o,
    output logic       is_m_o
);

    logic legal;

    always_comb begin
        ctrl_o          = '0;
        is_m_o          = 1'b0;
        legal           = 1'b1;
        ctrl_o.valid    = 1'b1;
        ctrl_o.str_ctrl = funct3_i;
        ctrl_o.imm_sel  = IMM_OTHER;
        ctrl_o.src_a    = SRCA_RS1;
        ctrl_o.src_b    = SRCB_RS2;

        case (opcode_i)
            OP_LOAD: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.imm_sel    = IMM_LS;
                ctrl_o.src_b      = SRCB_IMM;
            end
            OP_STORE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.imm_sel   = IMM_LS;
                ctrl_o.src_b     = SRCB_IMM;
            end
            OP_ALUREG: begin
                if (funct7_i == F7_BASE || funct7_i == F7_ALT) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = {1'b0, funct7_i[5], funct3_i};
                end else if (funct7_i == F7_MEXT && EN_M != 0) begin
                    ctrl_o.reg_write = 1'b1;
                    ctrl_o.alu_op    = {2'b10, funct3_i};
                    is_m_o           = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_ALUIMM: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm_sel   = IMM_I;
                ctrl_o.src_b     = SRCB_IMM;
                // Only the shift-right immediate uses funct7[5] (SRLI vs SRAI).
                ctrl_o.alu_op    = {1'b0, (funct3_i == 3'b101) ? funct7_i[5] : 1'b0, funct3_i};
            end
            OP_BRANCH: begin
                ctrl_o.pc_branch = 1'b1;
                ctrl_o.imm_sel   = IMM_B;
                ctrl_o.alu_op    = {2'b00, funct3_i};
            end
            OP_JAL: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.pc_branch = 1'b1;
                ctrl_o.imm_sel   = IMM_J;
                ctrl_o.src_a     = SRCA_PC;
                ctrl_o.src_b     = SRCB_FOUR;
            end
            OP_JALR: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.pc_branch = 1'b1;
                ctrl_o.imm_sel   = IMM_I;
                ctrl_o.src_a     = SRCA_PC;
                ctrl_o.src_b     = SRCB_FOUR;
            end
            OP_LUI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm_sel   = IMM_U;
                ctrl_o.src_a     = SRCA_ZERO;
                ctrl_o.src_b     = SRCB_IMM;
            end
            OP_AUIPC: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.imm_sel   = IMM_U;
                ctrl_o.src_a     = SRCA_PC;
                ctrl_o.src_b     = SRCB_IMM;
            end
            default: legal = 1'b0;
        endcase

        // Illegal slots stay valid so the exception reaches later stages, but never side-effect.
        if (!legal) begin
            ctrl_o.illegal    = 1'b1;
            ctrl_o.reg_write  = 1'b0;
            ctrl_o.mem_write  = 1'b0;
            ctrl_o.pc_branch  = 1'b0;
            ctrl_o.mem_to_reg = 1'b0;
            ctrl_o.alu_op     = 5'd0;
            is_m_o            = 1'b0;
        end

        if (!valid_i) begin
            ctrl_o = '0;
            is_m_o = 1'b0;
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// D->E control pipeline register with stall/flush handling and a busy FSM that holds
// multi-cycle M-extension ops in E for MD_LATENCY cycles.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int EN_M       = 1,
    parameter int MD_LATENCY = 4,
    parameter int ALUOP_W    = 5
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               validD,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               stallD,
    input  logic               flushE,
    output logic               validE,
    output logic               illegalE,
    output logic               RegWriteE,
    output logic               MemWriteE,
    output logic               PCBranchE,
    output logic               MemtoRegE,
    output logic [ALUOP_W-1:0] ALUopE,
    output logic [2:0]         immSelE,
    output logic [2:0]         strCtrlE,
    output logic [1:0]         SrcASelE,
    output logic [1:0]         SrcBSelE,
    output logic               mdBusy
);

    localparam int              CNT_W    = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam bit              MULTI    = (MD_LATENCY > 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MD_LATENCY > 1) ? MD_LATENCY - 2 : 0);

    ctrl_t            dec_d;
    logic             dec_is_m_d;
    ctrl_t            e_q;
    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             capture_d;

    ctrl_decode #(.EN_M(EN_M)) u_decode (
        .valid_i  (validD),
        .opcode_i (opcode),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .ctrl_o   (dec_d),
        .is_m_o   (dec_is_m_d)
    );

    // The edge that retires the last BUSY cycle also accepts the next D instruction.
    assign capture_d = !stallD &&
                       (state_q == ST_IDLE || (state_q == ST_BUSY && cnt_q == '0));

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            e_q     <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            if (state_q == ST_START) begin
                state_q <= ST_BUSY;
            end else if (state_q == ST_BUSY) begin
                if (cnt_q == '0) begin
                    state_q <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            if (capture_d) begin
                e_q <= dec_d;
                if (MULTI && dec_is_m_d) begin
                    state_q <= ST_START;
                    cnt_q   <= CNT_LOAD;
                end
            end
        end
    end

    assign validE    = e_q.valid;
    assign illegalE  = e_q.illegal;
    assign RegWriteE = e_q.reg_write;
    assign MemWriteE = e_q.mem_write;
    assign PCBranchE = e_q.pc_branch;
    assign MemtoRegE = e_q.mem_to_reg;
    assign ALUopE    = e_q.alu_op;
    assign immSelE   = e_q.imm_sel;
    assign strCtrlE  = e_q.str_ctrl;
    assign SrcASelE  = e_q.src_a;
    assign SrcBSelE  = e_q.src_b;
    assign mdBusy    = (state_q == ST_BUSY);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed and randomized checks of decode_ctrl_pipe: one instance with M ops over four
// cycles, one with the M extension disabled and single-cycle latency.
module tb_decode_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       rw;
        logic       mw;
        logic       pcb;
        logic       m2r;
        logic [4:0] alu;
        logic [2:0] imm;
        logic [2:0] strc;
        logic [1:0] sa;
        logic [1:0] sb;
    } exp_t;

    logic clk = 1'b0;
    logic rst, validD, stallD, flushE;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;

    logic       v0, il0, rw0, mw0, pb0, mr0, busy0;
    logic [4:0] alu0;
    logic [2:0] imm0, str0;
    logic [1:0] sa0, sb0;
    logic       v1, il1, rw1, mw1, pb1, mr1, busy1;
    logic [4:0] alu1;
    logic [2:0] imm1, str1;
    logic [1:0] sa1, sb1;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    exp_t exp_e [2];
    bit   exp_m [2];
    int   age   [2];
    int   lat_k [2];
    bit   enm_k [2];

    always #5 clk = ~clk;

    decode_ctrl_pipe #(.EN_M(1), .MD_LATENCY(4), .ALUOP_W(5)) dut0 (
        .clk(clk), .rst(rst), .validD(validD), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stallD(stallD), .flushE(flushE), .validE(v0), .illegalE(il0),
        .RegWriteE(rw0), .MemWriteE(mw0), .PCBranchE(pb0), .MemtoRegE(mr0), .ALUopE(alu0),
        .immSelE(imm0), .strCtrlE(str0), .SrcASelE(sa0), .SrcBSelE(sb0), .mdBusy(busy0)
    );

    decode_ctrl_pipe #(.EN_M(0), .MD_LATENCY(1), .ALUOP_W(5)) dut1 (
        .clk(clk), .rst(rst), .validD(validD), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .stallD(stallD), .flushE(flushE), .validE(v1), .illegalE(il1),
        .RegWriteE(rw1), .MemWriteE(mw1), .PCBranchE(pb1), .MemtoRegE(mr1), .ALUopE(alu1),
        .immSelE(imm1), .strCtrlE(str1), .SrcASelE(sa1), .SrcBSelE(sb1), .mdBusy(busy1)
    );

    // Reference decode straight from the instruction-class table.
    function automatic exp_t model_dec(input bit en_m, input logic v, input logic [6:0] op,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       output bit m);
        exp_t r;
        bit   ok;
        r  = '0;
        m  = 1'b0;
        ok = 1'b1;
        if (!v) return r;
        r.valid = 1'b1; r.strc = f3; r.sa = 2'b11; r.sb = 2'd0; r.imm = 3'd5;
        case (op)
            7'h03: begin r.rw = 1; r.m2r = 1; r.imm = 3'd2; r.sb = 2'd1; end
            7'h23: begin r.mw = 1; r.imm = 3'd2; r.sb = 2'd1; end
            7'h33: begin
                if (f7 == 7'h00) begin r.rw = 1; r.alu = {2'b00, f3}; end
                else if (f7 == 7'h20) begin r.rw = 1; r.alu = {2'b01, f3}; end
                else if (f7 == 7'h01 && en_m) begin r.rw = 1; r.alu = {2'b10, f3}; m = 1'b1; end
                else ok = 1'b0;
            end
            7'h13: begin
                r.rw = 1; r.imm = 3'd0; r.sb = 2'd1;
                r.alu = (f3 == 3'd5 && f7 == 7'h20) ? {2'b01, f3} : {2'b00, f3};
                if (f3 == 3'd5 && f7 != 7'h20 && f7 >= 7'h20) r.alu = {1'b0, f7 >= 7'h20 && f7 <= 7'h3F, f3};
                if (f3 == 3'd5 && f7 > 7'h3F) r.alu = (f7 >= 7'h60) ? {2'b01, f3} : {2'b00, f3};
            end
            7'h63: begin r.pcb = 1; r.imm = 3'd3; r.alu = {2'b00, f3}; end
            7'h6F: begin r.rw = 1; r.pcb = 1; r.imm = 3'd4; r.sa = 2'b00; r.sb = 2'd2; end
            7'h67: begin r.rw = 1; r.pcb = 1; r.imm = 3'd0; r.sa = 2'b00; r.sb = 2'd2; end
            7'h37: begin r.rw = 1; r.imm = 3'd1; r.sa = 2'b01; r.sb = 2'd1; end
            7'h17: begin r.rw = 1; r.imm = 3'd1; r.sa = 2'b00; r.sb = 2'd1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            r.illegal = 1; r.rw = 0; r.mw = 0; r.pcb = 0; r.m2r = 0; r.alu = '0; m = 1'b0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: an M op sits in E for lat cycles; busy reported on its cycles 2..lat.
    task automatic model_edge(input int k);
        exp_t d;
        bit   m;
        d = model_dec(enm_k[k], validD, opcode, funct3, funct7, m);
        if (rst || flushE) begin
            exp_e[k] = '0; exp_m[k] = 0; age[k] = 0;
        end else if ((exp_m[k] && age[k] < lat_k[k]) || stallD) begin
            age[k]++;
        end else begin
            exp_e[k] = d; exp_m[k] = m; age[k] = 1;
        end
    endtask

    task automatic step();
        logic [20:0] o0, o1;
        logic        b0, b1;
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        cyc++;
        o0 = {v0, il0, rw0, mw0, pb0, mr0, alu0, imm0, str0, sa0, sb0};
        o1 = {v1, il1, rw1, mw1, pb1, mr1, alu1, imm1, str1, sa1, sb1};
        b0 = exp_m[0] && lat_k[0] > 1 && age[0] >= 2 && age[0] <= lat_k[0];
        b1 = exp_m[1] && lat_k[1] > 1 && age[1] >= 2 && age[1] <= lat_k[1];
        chk($sformatf("c%0d_dut0_E", cyc), 32'(o0), 32'(exp_e[0]));
        chk($sformatf("c%0d_dut0_busy", cyc), 32'(busy0), 32'(b0));
        chk($sformatf("c%0d_dut1_E", cyc), 32'(o1), 32'(exp_e[1]));
        chk($sformatf("c%0d_dut1_busy", cyc), 32'(busy1), 32'(b1));
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7);
        validD = v; opcode = op; funct3 = f3; funct7 = f7;
    endtask

    initial begin
        logic [6:0] op_tab [9];
        lat_k[0] = 4; lat_k[1] = 1; enm_k[0] = 1'b1; enm_k[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin exp_e[k] = '0; exp_m[k] = 0; age[k] = 0; end
        op_tab = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        rst = 1; stallD = 0; flushE = 0;
        drive(1, 7'h33, 3'd0, 7'h00);
        step(); step();
        chk("reset_validE", 32'(v0), 0);
        chk("reset_mdBusy", 32'(busy0), 0);
        chk("reset_RegWrite", 32'(rw0), 0);

        rst = 0;
        drive(1, 7'h33, 3'd0, 7'h00);                // ADD
        step();
        chk("add_validE", 32'(v0), 1);
        chk("add_RegWrite", 32'(rw0), 1);
        chk("add_ALUop", 32'(alu0), 32'h00);
        chk("add_SrcB", 32'(sb0), 0);

        drive(1, 7'h33, 3'd0, 7'h20);                // SUB
        step();
        chk("sub_ALUop", 32'(alu0), 32'h08);
        drive(1, 7'h03, 3'd2, 7'h00);                // LW
        step();
        chk("lw_MemtoReg", 32'(mr0), 1);
        chk("lw_immSel", 32'(imm0), 2);
        chk("lw_SrcB", 32'(sb0), 1);

        drive(1, 7'h33, 3'd0, 7'h01);                // MUL
        step();
        chk("mul_c1_ALUop", 32'(alu0), 32'h10);
        chk("mul_c1_busy", 32'(busy0), 0);
        chk("noM_mul_illegal", 32'(il1), 1);
        chk("noM_mul_validE", 32'(v1), 1);
        chk("noM_mul_RegWrite", 32'(rw1), 0);
        chk("noM_mul_MemWrite", 32'(mw1), 0);
        drive(1, 7'h33, 3'd4, 7'h00);                // XOR waits in D
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("mul_c%0d_ALUop", c), 32'(alu0), 32'h10);
            chk($sformatf("mul_c%0d_busy", c), 32'(busy0), 1);
        end
        step();
        chk("mul_c5_next_ALUop", 32'(alu0), 32'h04);
        chk("mul_c5_busy", 32'(busy0), 0);

        drive(1, 7'h33, 3'd1, 7'h01);                // MULH, aborted by flush
        step();
        drive(1, 7'h33, 3'd0, 7'h00);
        step();
        chk("abort_busy_before", 32'(busy0), 1);
        flushE = 1;
        step();
        flushE = 0;
        chk("abort_validE", 32'(v0), 0);
        chk("abort_busy", 32'(busy0), 0);
        step();
        chk("abort_next_validE", 32'(v0), 1);
        chk("abort_next_ALUop", 32'(alu0), 32'h00);

        drive(1, 7'h7F, 3'd0, 7'h00);                // unknown opcode
        step();
        chk("op7F_illegal", 32'(il0), 1);
        chk("op7F_validE", 32'(v0), 1);
        chk("op7F_RegWrite", 32'(rw0), 0);
        chk("op7F_MemWrite", 32'(mw0), 0);

        drive(1, 7'h6F, 3'd0, 7'h00);                // JAL, then stalled
        step();
        drive(1, 7'h33, 3'd0, 7'h00);
        stallD = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("jal_stall%0d_PCBranch", c), 32'(pb0), 1);
            chk($sformatf("jal_stall%0d_SrcB", c), 32'(sb0), 2);
        end
        flushE = 1;
        step();
        chk("flush_stall_validE", 32'(v0), 0);
        chk("flush_stall_PCBranch", 32'(pb0), 0);
        flushE = 0; stallD = 0;

        for (int i = 0; i < 400; i++) begin
            logic [6:0] f7r;
            case ($urandom_range(0, 3))
                0: f7r = 7'h00;
                1: f7r = 7'h20;
                2: f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            drive(($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 8)],
                  3'($urandom), f7r);
            stallD = ($urandom_range(0, 9) < 2);
            flushE = ($urandom_range(0, 19) == 0);
            rst    = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
